// File: rtl/not_delay_checker_pkg.sv
// ============================================================================
// Module   : not_delay_chk_pkg
// Brief    : Shared state encoding and default constants for not_delay_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package not_delay_chk_pkg;

  localparam int   c_cnt_w_default   = 8;
  localparam int   c_timeout_default = 15;
  // Probe drives 0 out of reset, so a healthy inverter presents 1.
  localparam logic c_sync_rst_val    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TOGGLE = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_FIN    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/not_delay_checker_if.sv
// ============================================================================
// Module   : not_delay_checker_if
// Brief    : Control, probe and result bundle between a stimulus driver
//            (master) and the checker (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface not_delay_checker_if
  import not_delay_chk_pkg::*;
#(
  parameter int CNT_W = c_cnt_w_default
);

  logic             start;
  logic [CNT_W-1:0] num_trials;
  logic             probe_out;
  logic             probe_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail_timeout;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] min_latency;
  logic [CNT_W-1:0] max_latency;

  modport master (
    output start, num_trials, probe_in,
    input  probe_out, busy, done, pass, fail_timeout,
           last_latency, min_latency, max_latency
  );

  modport slave (
    input  start, num_trials, probe_in,
    output probe_out, busy, done, pass, fail_timeout,
           last_latency, min_latency, max_latency
  );

endinterface

`default_nettype wire

// File: rtl/not_delay_checker_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer, synchronous active-low reset to RST_VAL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/not_delay_checker.sv
// ============================================================================
// Module   : not_delay_checker
// Brief    : Toggles an inverter input, times the synchronized response and
//            reports pass/timeout/latency stats. NOT_DELAY_CHK_MINMAX_EN
//            builds real min/max trackers; otherwise both mirror last_latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module not_delay_checker
  import not_delay_chk_pkg::*;
#(
  parameter int CNT_W   = c_cnt_w_default,
  parameter int TIMEOUT = c_timeout_default
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  not_delay_checker_if.slave chk
);

  localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_ones    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_sync_in;
  logic             w_accept;
  logic             w_toggle;
  logic             w_match;
  logic             w_timeout;
  logic             w_count;
  logic             w_finish;

  logic             r_probe_out;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail_timeout;
  logic [CNT_W-1:0] r_last_lat;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_cnt;

  sync_2ff #(
    .RST_VAL (c_sync_rst_val)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chk.probe_in),
    .q     (w_sync_in)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_toggle     = 1'b0;
    w_match      = 1'b0;
    w_timeout    = 1'b0;
    w_count      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (chk.start) begin
          w_accept     = 1'b1;
          w_next_state = (chk.num_trials == '0) ? S_FIN : S_TOGGLE;
        end
      end
      S_TOGGLE: begin
        w_toggle     = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        // A match on the timeout cycle still counts as a matched trial.
        if (w_sync_in == ~r_probe_out) begin
          w_match      = 1'b1;
          w_next_state = (r_remaining == c_cnt_one) ? S_FIN : S_GAP;
        end else if (r_cnt == c_timeout_cnt) begin
          w_timeout    = 1'b1;
          w_next_state = S_FIN;
        end else begin
          w_count = 1'b1;
        end
      end
      S_GAP: begin
        w_next_state = S_TOGGLE;
      end
      S_FIN: begin
        w_finish     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // r_cnt holds the edge index Ek at which the current compare resolves,
  // so the value captured on a match is the reported latency directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_probe_out    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_fail_timeout <= 1'b0;
      r_last_lat     <= '0;
      r_remaining    <= '0;
      r_cnt          <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_remaining    <= chk.num_trials;
        r_busy         <= 1'b1;
        r_pass         <= 1'b0;
        r_fail_timeout <= 1'b0;
        r_last_lat     <= '0;
      end
      if (w_toggle) begin
        r_probe_out <= ~r_probe_out;
        r_cnt       <= c_cnt_one;
      end
      if (w_match) begin
        r_last_lat  <= r_cnt;
        r_remaining <= r_remaining - c_cnt_one;
      end
      if (w_timeout) begin
        r_fail_timeout <= 1'b1;
      end
      if (w_count && (r_cnt != c_cnt_ones)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (w_finish) begin
        r_done <= 1'b1;
        r_pass <= ~r_fail_timeout;
        r_busy <= 1'b0;
      end
    end
  end

`ifdef NOT_DELAY_CHK_MINMAX_EN
  logic [CNT_W-1:0] r_min_lat;
  logic [CNT_W-1:0] r_max_lat;

  always_ff @(posedge clk) begin
    if (!rst_n || w_accept) begin
      r_min_lat <= '1;
      r_max_lat <= '0;
    end else if (w_match) begin
      if (r_cnt < r_min_lat) r_min_lat <= r_cnt;
      if (r_cnt > r_max_lat) r_max_lat <= r_cnt;
    end
  end

  assign chk.min_latency = r_min_lat;
  assign chk.max_latency = r_max_lat;
`else
  assign chk.min_latency = r_last_lat;
  assign chk.max_latency = r_last_lat;
`endif

  assign chk.probe_out    = r_probe_out;
  assign chk.busy         = r_busy;
  assign chk.done         = r_done;
  assign chk.pass         = r_pass;
  assign chk.fail_timeout = r_fail_timeout;
  assign chk.last_latency = r_last_lat;

endmodule

`default_nettype wire

// File: tb/tb_not_delay_checker.sv
// ============================================================================
// Module   : tb_not_delay_checker
// Brief    : Self-checking bench: inverter model with variable delay or stuck
//            output, reference model of run timing and statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_not_delay_checker;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 15;
  localparam int PERIOD  = 10;
`ifdef NOT_DELAY_CHK_MINMAX_EN
  localparam logic [7:0] c_min_rst = 8'hFF;
`else
  localparam logic [7:0] c_min_rst = 8'h00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  not_delay_checker_if #(.CNT_W(CNT_W)) ifc ();

  not_delay_checker #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .chk   (ifc.slave)
  );

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   gate_delay = 2;
  logic gate_q     = 1'b1;
  logic stuck_en   = 1'b0;
  logic stuck_val  = 1'b0;

  // Transport-delay inverter; stuck_en overrides its output.
  always @(ifc.probe_out) gate_q <= #(gate_delay) ~ifc.probe_out;
  assign ifc.probe_in = stuck_en ? stuck_val : gate_q;

  typedef struct {
    int         edges;   // negedges from the accepting edge until done is seen
    int         toggles;
    logic       pass;
    logic       ft;
    logic [7:0] last;
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_t;

  // d < 0 means the gate output is stuck at the wrong level.
  function automatic exp_t model(input int n, input int d1, input int d2);
    exp_t e;
    int   d;
    int   lat;
    e.edges = 1; e.toggles = 0; e.ft = 1'b0;
    e.last = 8'd0; e.mn = 8'hFF; e.mx = 8'd0;
    if (n == 0) e.edges = 2;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d1 : d2;
      lat = (d < 0) ? TIMEOUT + 1 : (d + PERIOD - 1) / PERIOD + 2;
      e.toggles++;
      if (lat > TIMEOUT) begin
        e.edges += TIMEOUT + 2;
        e.ft = 1'b1;
        break;
      end
      e.edges += lat + 2;
      e.last = lat[7:0];
      if (lat < int'(e.mn)) e.mn = lat[7:0];
      if (lat > int'(e.mx)) e.mx = lat[7:0];
    end
    e.pass = ~e.ft;
`ifndef NOT_DELAY_CHK_MINMAX_EN
    e.mn = e.last;
    e.mx = e.last;
`endif
    return e;
  endfunction

  task automatic run_scenario(input string label, input int n, input int d1, input int d2);
    exp_t e;
    int   edges;
    int   toggles;
    logic busy_first;
    logic done_next;
    logic prev;
    bit   switched;
    repeat (16) @(negedge clk);
    e = model(n, d1, d2);
    if (d1 < 0) begin
      stuck_val = ~ifc.probe_out;
      stuck_en  = 1'b1;
    end else begin
      gate_delay = d1;
    end
    repeat (2) @(negedge clk);
    prev = ifc.probe_out;
    ifc.start      = 1'b1;
    ifc.num_trials = 8'(n);
    @(negedge clk);
    ifc.start      = 1'b0;
    ifc.num_trials = 8'($urandom);
    edges = 1; toggles = 0; switched = 0;
    busy_first = ifc.busy;
    forever begin
      if (ifc.probe_out !== prev) begin
        toggles++;
        prev = ifc.probe_out;
        if (!switched && d1 >= 0 && d2 != d1) begin
          gate_delay = d2;
          switched   = 1;
        end
      end
      if (ifc.done === 1'b1 || edges >= 800) break;
      // A second start while busy must be ignored.
      ifc.start = (n > 0 && edges == 3);
      @(negedge clk);
      edges++;
    end
    ifc.start = 1'b0;
    @(negedge clk);
    done_next = ifc.done;
    stuck_en  = 1'b0;

    n_checks++; if (edges !== e.edges) begin n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d", label, edges, e.edges); end
    n_checks++; if (toggles !== e.toggles) begin n_fail++;
      $display("FAIL %s toggles: got %0d want %0d", label, toggles, e.toggles); end
    n_checks++; if (busy_first !== 1'b1) begin n_fail++;
      $display("FAIL %s busy_rise: got %b want 1", label, busy_first); end
    n_checks++; if (done_next !== 1'b0) begin n_fail++;
      $display("FAIL %s done_width: got %b want 0", label, done_next); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++;
      $display("FAIL %s busy_end: got %b want 0", label, ifc.busy); end
    n_checks++; if (ifc.pass !== e.pass) begin n_fail++;
      $display("FAIL %s pass: got %b want %b", label, ifc.pass, e.pass); end
    n_checks++; if (ifc.fail_timeout !== e.ft) begin n_fail++;
      $display("FAIL %s timeout: got %b want %b", label, ifc.fail_timeout, e.ft); end
    n_checks++; if (ifc.last_latency !== e.last) begin n_fail++;
      $display("FAIL %s last_lat: got %0d want %0d", label, ifc.last_latency, e.last); end
    n_checks++; if (ifc.min_latency !== e.mn) begin n_fail++;
      $display("FAIL %s min_lat: got %0d want %0d", label, ifc.min_latency, e.mn); end
    n_checks++; if (ifc.max_latency !== e.mx) begin n_fail++;
      $display("FAIL %s max_lat: got %0d want %0d", label, ifc.max_latency, e.mx); end
  endtask

  task automatic check_reset_values(input string label);
    n_checks++; if (ifc.probe_out !== 1'b0) begin n_fail++;
      $display("FAIL %s probe_out: got %b want 0", label, ifc.probe_out); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_fail++;
      $display("FAIL %s busy: got %b want 0", label, ifc.busy); end
    n_checks++; if (ifc.done !== 1'b0) begin n_fail++;
      $display("FAIL %s done: got %b want 0", label, ifc.done); end
    n_checks++; if (ifc.pass !== 1'b0) begin n_fail++;
      $display("FAIL %s pass: got %b want 0", label, ifc.pass); end
    n_checks++; if (ifc.fail_timeout !== 1'b0) begin n_fail++;
      $display("FAIL %s timeout: got %b want 0", label, ifc.fail_timeout); end
    n_checks++; if (ifc.last_latency !== 8'd0) begin n_fail++;
      $display("FAIL %s last_lat: got %0d want 0", label, ifc.last_latency); end
    n_checks++; if (ifc.min_latency !== c_min_rst) begin n_fail++;
      $display("FAIL %s min_lat: got %0d want %0d", label, ifc.min_latency, c_min_rst); end
    n_checks++; if (ifc.max_latency !== 8'd0) begin n_fail++;
      $display("FAIL %s max_lat: got %0d want 0", label, ifc.max_latency); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_fast_gate();
    run_scenario("fast_gate", 4, 2, 2);
  endtask

  task automatic test_slow_gate();
    run_scenario("slow_gate", 3, 25, 25);
  endtask

  task automatic test_stuck_output();
    run_scenario("stuck", 5, -1, -1);
  endtask

  task automatic test_zero_trials();
    run_scenario("zero_trials", 0, 2, 2);
  endtask

  task automatic test_timeout_boundary();
    run_scenario("lat_eq_timeout", 2, 125, 125);
    run_scenario("lat_over_timeout", 2, 135, 135);
  endtask

  task automatic test_delay_switch();
    run_scenario("delay_switch", 3, 2, 25);
  endtask

  task automatic test_reset_midrun();
    logic prev;
    int   tog = 0;
    bit   seen_done = 0;
    repeat (16) @(negedge clk);
    gate_delay = 2;
    prev = ifc.probe_out;
    ifc.start      = 1'b1;
    ifc.num_trials = 8'd4;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int i = 0; i < 100 && tog < 2; i++) begin
      @(negedge clk);
      if (ifc.probe_out !== prev) begin
        tog++;
        prev = ifc.probe_out;
      end
    end
    n_checks++; if (tog !== 2) begin n_fail++;
      $display("FAIL midrun toggles_before_reset: got %0d want 2", tog); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values("midrun_reset");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) seen_done = 1;
    end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++;
      $display("FAIL midrun no_done: got %b want 0", seen_done); end
    run_scenario("after_reset", 2, 2, 2);
  endtask

  task automatic test_random();
    int n;
    int d;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 4));
      d = int'($urandom_range(1, 145));
      if (d % PERIOD == 0) d = d + 1;
      run_scenario($sformatf("random%0d_n%0d_d%0d", k, n, d), n, d, d);
    end
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.num_trials = '0;
    test_reset();
    test_fast_gate();
    test_slow_gate();
    test_stuck_output();
    test_zero_trials();
    test_reset_midrun();
    test_delay_switch();
    test_timeout_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
